// File: rtl/wishbone_op_master.sv
// Single-cycle Wishbone master: turns one four-phase op request into one classic
// bus cycle and reports read data, completion and error status back to the requester.
module wishbone_op_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // requester side
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] select,
  input  logic [1:0]              op_code,
  input  logic                    do_work,
  output logic                    work_done,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    error,
  // Wishbone side
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen at the edge that completes TIMEOUT_CYCLES silent bus cycles.
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] tmo_cnt;

  // NOTE: state and every output are registers updated with <= only; the async
  // reset clears them immediately, so a reset mid-cycle drops cyc/stb at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      work_done <= 1'b0;
      data_out  <= '0;
      error     <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (do_work) begin
            case (op_code)
              OP_WRITE, OP_READ: begin
                wb_adr_o <= address;
                wb_dat_o <= data_in;
                wb_sel_o <= select;
                wb_we_o  <= (op_code == OP_WRITE);
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                tmo_cnt  <= '0;
                state    <= ST_BUS;
              end
              OP_NOP: begin
                error     <= 1'b0;
                work_done <= 1'b1;
                state     <= ST_DONE;
              end
              default: begin
                error     <= 1'b1;
                work_done <= 1'b1;
                state     <= ST_DONE;
              end
            endcase
          end
        end

        ST_BUS: begin
          if (wb_ack_i || wb_err_i || (tmo_cnt == TMO_LAST)) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            work_done <= 1'b1;
            state     <= ST_DONE;
            // err beats ack; no response at all means a timeout
            if (wb_err_i || !wb_ack_i) begin
              error <= 1'b1;
            end else begin
              error <= 1'b0;
              if (!wb_we_o) data_out <= wb_dat_i;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
          end
        end

        ST_DONE: begin
          if (!do_work) begin
            work_done <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_op_master.sv
// Self-checking bench for wishbone_op_master: directed scenarios plus randomized
// ops, each compared against an outcome model derived from the op/response rules.
module tb_wishbone_op_master;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address, data_in;
  logic [3:0]  select;
  logic [1:0]  op_code;
  logic        do_work;
  logic        work_done;
  logic [31:0] data_out;
  logic        error;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_data;  // expected data_out: last successful READ since reset

  wishbone_op_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .data_in  (data_in),
    .select   (select),
    .op_code  (op_code),
    .do_work  (do_work),
    .work_done(work_done),
    .data_out (data_out),
    .error    (error),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // resp: 0 = ack, 1 = err, 2 = ack+err together, 3 = silent slave.
  // delay: the stb cycle (1-based) in which the response is given.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int resp, input int delay, input logic [31:0] rdata);
    int   exp_cyc, edges, cyc_cnt;
    logic exp_err, timed_out;
    exp_cyc   = 0;
    exp_err   = 1'b0;
    timed_out = 1'b0;
    if (op == 2'd3) begin
      exp_err = 1'b1;
    end else if (op != 2'd0) begin
      if (resp == 3 || delay > T) begin
        exp_cyc   = T;
        exp_err   = 1'b1;
        timed_out = 1'b1;
      end else begin
        exp_cyc = delay;
        exp_err = (resp != 0);
        if (resp == 0 && op == 2'd2) model_data = rdata;
      end
    end

    address = adr; data_in = dat; select = sel; op_code = op; do_work = 1'b1;
    edges = 0; cyc_cnt = 0;
    while (!work_done && edges < 40) begin
      check({name, " stb==cyc"}, wb_stb_o, wb_cyc_o);
      if (wb_cyc_o) begin
        cyc_cnt++;
        check({name, " adr"}, wb_adr_o, adr);
        check({name, " dat"}, wb_dat_o, dat);
        check({name, " sel"}, wb_sel_o, sel);
        check({name, " we"}, wb_we_o, (op == 2'd1));
        wb_dat_i = rdata;
        wb_ack_i = (resp == 0 || resp == 2) && (cyc_cnt == delay);
        wb_err_i = (resp == 1 || resp == 2) && (cyc_cnt == delay);
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end
      step();
      edges++;
      // requester changes after accept must not reach the bus
      address = $urandom; data_in = $urandom; select = 4'($urandom); op_code = 2'($urandom);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;

    check({name, " work_done"}, work_done, 1'b1);
    check({name, " latency"}, edges, exp_cyc + 1);
    check({name, " cyc_cycles"}, cyc_cnt, exp_cyc);
    check({name, " error"}, error, exp_err);
    check({name, " data_out"}, data_out, model_data);
    check({name, " cyc_after"}, wb_cyc_o, 1'b0);
    if (exp_cyc > 0 && !timed_out) check({name, " we_after"}, wb_we_o, 1'b0);

    // do_work held high through DONE: no re-accept, status stable
    op_code = 2'd1;
    repeat (2) step();
    check({name, " hold work_done"}, work_done, 1'b1);
    check({name, " hold cyc"}, wb_cyc_o, 1'b0);
    check({name, " hold error"}, error, exp_err);
    check({name, " hold data_out"}, data_out, model_data);

    do_work = 1'b0;
    step();
    check({name, " release work_done"}, work_done, 1'b0);
    check({name, " release error"}, error, exp_err);
    check({name, " release cyc"}, wb_cyc_o, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    address = '0; data_in = '0; select = '0; op_code = '0; do_work = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    model_data = '0;

    step();
    check("reset work_done", work_done, 1'b0);
    check("reset error", error, 1'b0);
    check("reset data_out", data_out, 32'h0);
    check("reset cyc", wb_cyc_o, 1'b0);
    check("reset stb", wb_stb_o, 1'b0);
    check("reset we", wb_we_o, 1'b0);
    reset_n = 1'b1;
    step();

    run_op("write_ack3", 2'd1, 32'h10, 32'hA5, 4'h1, 0, 3, 32'hDEAD_BEEF);
    run_op("read_ack1", 2'd2, 32'h14, 32'h0, 4'hF, 0, 1, 32'h0000_0060);
    run_op("read_timeout", 2'd2, 32'h18, 32'h0, 4'hF, 3, 0, 32'h1234_5678);
    run_op("illegal_op", 2'd3, 32'h20, 32'h0, 4'hF, 0, 1, 32'h0);
    run_op("nop_op", 2'd0, 32'h24, 32'h0, 4'hF, 0, 1, 32'h0);
    run_op("write_ack_err", 2'd1, 32'h1C, 32'h77, 4'h3, 2, 2, 32'h0);
    run_op("read_err", 2'd2, 32'h0C, 32'h0, 4'hF, 1, 1, 32'hFFFF_FFFF);
    run_op("read_ack_at_limit", 2'd2, 32'h08, 32'h0, 4'hF, 0, T, 32'h0000_00C3);

    // reset in the middle of a bus cycle
    address = 32'h30; op_code = 2'd2; select = 4'hF; do_work = 1'b1;
    step();
    do_work = 1'b0;
    repeat (2) step();
    check("midbus cyc_before", wb_cyc_o, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midbus cyc", wb_cyc_o, 1'b0);
    check("midbus stb", wb_stb_o, 1'b0);
    check("midbus work_done", work_done, 1'b0);
    check("midbus data_out", data_out, 32'h0);
    model_data = '0;
    #2;
    reset_n = 1'b1;
    step();
    check("post_reset work_done", work_done, 1'b0);
    run_op("read_after_reset", 2'd2, 32'h14, 32'h0, 4'hF, 0, 2, 32'h0000_0042);

    for (int i = 0; i < 40; i++) begin
      run_op("random", 2'($urandom), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(1, T + 2)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
